// File: rtl/axis_width_conv_pkg.sv
// Helpers and constants shared by the AXI-stream width converters
// (wide-to-narrow and narrow-to-wide).
package axis_width_conv_pkg;

    localparam int BIT_COUNT_W = 16;

    // Number of narrow slices that make up one wide word.
    function automatic int widthRatio(input int wide, input int narrow);
        return (narrow > 0) ? (wide / narrow) : 0;
    endfunction

    // A converter pair is legal only for an exact integer ratio of at least two.
    function automatic bit ratioLegal(input int wide, input int narrow);
        return (narrow > 0) && (wide % narrow == 0) && (wide / narrow >= 2);
    endfunction

endpackage

// File: rtl/axis_width_conv_wide_narrow.sv
// Splits each M-bit word from a first-word-fall-through source into M/N
// narrow slices, most significant slice first.
module axis_width_conv_wide_narrow
    import axis_width_conv_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   s_axis_tnext,
    input  logic [M-1:0]           s_axis_tdata,
    input  logic                   s_axis_tfirst,
    input  logic                   s_axis_tvalid,
    input  logic                   m_axis_tnext,
    output logic [N-1:0]           m_axis_tdata,
    output logic                   m_axis_tfirst,
    output logic                   m_axis_tvalid,
    output logic [BIT_COUNT_W-1:0] bit_count
);

    localparam int K  = widthRatio(M, N);
    localparam int CW = (K < 1) ? 1 : $clog2(K + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(K);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    generate
        if (!ratioLegal(M, N)) begin : gRatioCheck
            $fatal(1, "axis_width_conv_wide_narrow: M must be a multiple K>=2 of N");
        end
    endgenerate

    logic [M-1:0]           hold_q, hold_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   first_q, first_d;
    logic [BIT_COUNT_W-1:0] bitCount_q, bitCount_d;
    logic                   popWord;
    logic                   advance;

    // A new word is taken when the register is empty, or when its last slice
    // leaves this cycle, so back-to-back words stream without a bubble.
    always_comb begin
        popWord = s_axis_tvalid && !rst &&
                  ((cnt_q == '0) || ((cnt_q == CNT_ONE) && m_axis_tnext));
        advance = m_axis_tnext && (cnt_q != '0);
    end

    always_comb begin
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        if (popWord) begin
            hold_d  = s_axis_tdata;
            cnt_d   = CNT_FULL;
            first_d = s_axis_tfirst;
        end else if (advance) begin
            hold_d  = {hold_q[M-N-1:0], {N{1'b0}}};
            cnt_d   = cnt_q - CNT_ONE;
            first_d = 1'b0;
        end
        bitCount_d = BIT_COUNT_W'(cnt_d) * BIT_COUNT_W'(N);
    end

    // bit_count is registered from cnt_d so it always tracks cnt_q exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            bitCount_q <= '0;
        end else begin
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            bitCount_q <= bitCount_d;
        end
    end

    assign s_axis_tnext  = popWord;
    assign m_axis_tdata  = hold_q[M-1 -: N];
    assign m_axis_tfirst = first_q;
    assign m_axis_tvalid = (cnt_q != '0);
    assign bit_count     = bitCount_q;

endmodule
